// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word and the RAM handshake state
// reported by the memory controller.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: one data requester and CPUS instruction requesters.
// Optional macro MEM_ARB_INST_RR_EN enables round-robin between instruction cores.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,

    input  logic                 bus_dREN,
    input  logic                 bus_dWEN,
    input  word_t                bus_daddr,
    input  word_t                bus_dstore,
    output word_t                bus_dload,
    output logic                 bus_dwait,

    input  logic [CPUS-1:0]      iREN,
    input  word_t [CPUS-1:0]     iaddr,
    output word_t [CPUS-1:0]     iload,
    output logic [CPUS-1:0]      iwait,

    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    arb_state_t state, next_state;
    logic       owner, next_owner;
`ifdef MEM_ARB_INST_RR_EN
    logic       last_served, next_last_served;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            owner       <= 1'b0;
`ifdef MEM_ARB_INST_RR_EN
            last_served <= 1'b1;
`endif
        end else begin
            state       <= next_state;
            owner       <= next_owner;
`ifdef MEM_ARB_INST_RR_EN
            last_served <= next_last_served;
`endif
        end
    end

    // NOTE: every output and next-state variable gets a default first so no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        next_owner = owner;
`ifdef MEM_ARB_INST_RR_EN
        next_last_served = last_served;
`endif
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        bus_dwait = 1'b1;
        iwait     = '1;
        bus_dload = ramload;
        for (int k = 0; k < CPUS; k++) begin
            iload[k] = ramload;
        end

        case (state)
            IDLE: begin
                if (bus_dREN || bus_dWEN) begin
                    next_state = DGRANT;
                end else if (|iREN) begin
                    next_state = IGRANT;
`ifdef MEM_ARB_INST_RR_EN
                    next_owner = (iREN[0] && iREN[1]) ? ~last_served : ~iREN[0];
`else
                    next_owner = ~iREN[0];
`endif
                end
            end

            DGRANT: begin
                // A dropped request abandons the access with strobes already low.
                if (!(bus_dREN || bus_dWEN)) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = bus_daddr;
                    ramstore = bus_dstore;
                    ramWEN   = bus_dWEN;
                    ramREN   = bus_dREN & ~bus_dWEN;
                    if (ramstate == ACCESS) begin
                        bus_dwait  = 1'b0;
                        next_state = IDLE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN[owner]) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[owner];
                    if (ramstate == ACCESS) begin
                        iwait[owner] = 1'b0;
                        next_state   = IDLE;
`ifdef MEM_ARB_INST_RR_EN
                        next_last_served = owner;
`endif
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: CPUS, 2, number of instruction requesters; only 2 is supported.
REQ-002 SHALL have port: CLK  in  1  system clock, rising edge.
REQ-003 SHALL have port: nRST  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: bus_dREN  in  1  data read request from bus controller.
REQ-005 SHALL have port: bus_dWEN  in  1  data write request from bus controller.
REQ-006 SHALL have port: bus_daddr  in  32  data word address.
REQ-007 SHALL have port: bus_dstore  in  32  data write value.
REQ-008 SHALL have port: bus_dload  out  32  data read value.
REQ-009 SHALL have port: bus_dwait  out  1  data not complete.
REQ-010 SHALL have port: iREN  in  CPUS  per-core instruction fetch request.
REQ-011 SHALL have port: iaddr  in  CPUS x 32  per-core fetch address.
REQ-012 SHALL have port: iload  out  CPUS x 32  per-core fetch data.
REQ-013 SHALL have port: iwait  out  CPUS  per-core fetch not complete.
REQ-014 SHALL have port: ramREN, ramWEN  out  1 each  RAM strobes.
REQ-015 SHALL have port: ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-016 SHALL have port: ramload  in  32  RAM read data.
REQ-017 SHALL have port: ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.

Function
REQ-018 SHALL implement FSM IDLE, DGRANT, IGRANT with a registered owner bit for IGRANT.
REQ-019 In IDLE: RAM strobes low, ramaddr/ramstore 0, all waits 1; bus_dREN|bus_dWEN -> DGRANT next cycle; else any iREN -> IGRANT next cycle.
REQ-020 Data SHALL have priority over instructions in IDLE; a granted instruction access SHALL NOT be preempted.
REQ-021 In DGRANT: ramaddr=bus_daddr, ramstore=bus_dstore; ramWEN=bus_dWEN; ramREN=bus_dREN & !bus_dWEN (write wins when both set).
REQ-022 In IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr[owner], ramstore=0.
REQ-023 When ramstate==ACCESS in a grant state, the owner's wait SHALL be 0 that same cycle and FSM SHALL return to IDLE next cycle.
REQ-024 Minimum latency: request seen in IDLE at cycle N, grant at N+1, earliest completion (wait low) at N+1.
REQ-025 ramstate BUSY, FREE or ERROR in a grant state: hold state, owner wait 1, strobes held.
REQ-026 If the owner drops its request while granted, FSM SHALL go to IDLE next cycle with strobes low that cycle and no wait deasserted.
REQ-027 bus_dload and iload[k] SHALL equal ramload combinationally at all times; non-owner waits stay 1.
REQ-028 Back-to-back: after completion, the next grant SHALL start no earlier than the following IDLE cycle (one idle bubble).

Reset
REQ-029 nRST low SHALL force state IDLE, owner 0, last-served-core 1 immediately, independent of CLK.
REQ-030 During and right after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, bus_dwait=1, iwait=all 1.
REQ-031 Reset mid-grant SHALL abandon the access; no wait deasserts for it.

Configuration
REQ-032 Macro MEM_ARB_INST_RR_EN defined: IGRANT owner = core other than last-served when both iREN set; last-served updates on each instruction completion.
REQ-033 Macro undefined: core 0 always wins simultaneous iREN; last-served register absent.

Structure
REQ-034 word_t and ramstate_t SHALL come from cpu_types_pkg; the arbiter state enum SHALL be local to the module.
REQ-035 No sub-module; single module with one always_ff and one always_comb.

Verification
REQ-036 Data read 0x40, ramstate BUSY 2 cycles then ACCESS, ramload 0xDEADBEEF -> bus_dload 0xDEADBEEF with bus_dwait 0 exactly one cycle, iwait 2'b11 throughout.
REQ-037 bus_dREN and iREN[0] both set in IDLE -> DGRANT first; iaddr[0] served in IGRANT only after data completes and one IDLE bubble.
REQ-038 iREN=2'b11 held, ACCESS every grant cycle: with MEM_ARB_INST_RR_EN completions alternate 0,1,0,1; without it core 0 only.
REQ-039 bus_dWEN and bus_dREN both 1, addr 0x80, store 0x12345678 -> ramWEN 1, ramREN 0, ramstore 0x12345678.
REQ-040 nRST asserted during IGRANT with ramstate BUSY -> outputs at reset values same cycle; no iwait 0 pulse after release.
REQ-041 Owner drops iREN[1] mid-IGRANT -> strobes low, IDLE next cycle, iwait[1] never 0.
